// File: rtl/fifo_frame_reader.sv
// FIFO frame reader: pops one frame of frame_len words from a FIFO with
// one-cycle read latency and streams them out through a 2-entry skid buffer.
module fifo_frame_reader #(
  parameter int WORD_SIZE = 16,
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic [LEN_W-1:0]     words_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     issued_q, issued_d;
  logic [LEN_W-1:0]     ws_q, ws_d;
  logic                 done_q, done_d;
  logic                 infl_q, infl_d;
  logic                 infl_last_q, infl_last_d;
  logic [1:0]           occ_q, occ_d;
  logic [WORD_SIZE-1:0] dat0_q, dat0_d;
  logic [WORD_SIZE-1:0] dat1_q, dat1_d;
  logic                 lst0_q, lst0_d;
  logic                 lst1_q, lst1_d;

  logic       pop;
  logic       rd;
  logic [2:0] fill;
  logic [2:0] limit;

  // Credit: buffered + in-flight words after this cycle's pop stay <= 2.
  assign pop   = m_valid & m_ready;
  assign fill  = {1'b0, occ_q} + {2'b00, infl_q};
  assign limit = 3'd2 + {2'b00, pop};
  assign rd    = (state_q == S_STREAM) & ~fifo_empty
               & (issued_q < len_q) & (fill < limit);

  assign fifo_read  = rd;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = dat0_q;
  assign m_last     = m_valid & lst0_q;
  assign words_sent = ws_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    ws_d        = ws_q;
    done_d      = 1'b0;
    infl_d      = rd;
    infl_last_d = infl_last_q;
    occ_d       = occ_q;
    dat0_d      = dat0_q;
    dat1_d      = dat1_q;
    lst0_d      = lst0_q;
    lst1_d      = lst1_q;

    if (rd) begin
      issued_d    = issued_q + ONE;
      infl_last_d = (issued_q == len_q - ONE);
    end

    if (pop) begin
      ws_d = ws_q + ONE;
    end

    unique case (1'b1)
      infl_q & ~pop: begin
        if (occ_q == 2'd0) begin
          dat0_d = fifo_data;
          lst0_d = infl_last_q;
        end else begin
          dat1_d = fifo_data;
          lst1_d = infl_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      ~infl_q & pop: begin
        dat0_d = dat1_q;
        lst0_d = lst1_q;
        occ_d  = occ_q - 2'd1;
      end
      infl_q & pop: begin
        if (occ_q == 2'd1) begin
          dat0_d = fifo_data;
          lst0_d = infl_last_q;
        end else begin
          dat0_d = dat1_q;
          lst0_d = lst1_q;
          dat1_d = fifo_data;
          lst1_d = infl_last_q;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = frame_len;
          issued_d = '0;
          ws_d     = '0;
          if (frame_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (issued_d == len_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pop && lst0_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      ws_q        <= '0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      dat0_q      <= '0;
      dat1_q      <= '0;
      lst0_q      <= 1'b0;
      lst1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      ws_q        <= ws_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      dat0_q      <= dat0_d;
      dat1_q      <= dat1_d;
      lst0_q      <= lst0_d;
      lst1_q      <= lst1_d;
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: FIFO model, random backpressure,
// and a monitor comparing each accepted word against the expected frame.
module tb_fifo_frame_reader;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          busy;
  logic          done;
  logic          fifo_empty;
  logic          fifo_read;
  logic [W-1:0]  fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [LW-1:0] words_sent;

  fifo_frame_reader #(.WORD_SIZE(W), .LEN_W(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency
  logic [W-1:0] mem [0:4095];
  int   rd_q = 0;
  int   wr = 0;
  logic hold_empty = 1'b0;

  assign fifo_empty = hold_empty || (rd_q == wr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data <= mem[rd_q % 4096];
      rd_q      <= rd_q + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [W:0] exp_q [$];
  int   exp_len [$];
  int   exp_rd = 0;
  int   frames_seen = 0;
  logic zlen = 1'b0;

  // Ready / empty drivers
  int rdy_mode = 0;
  int emp_mode = 0;
  int pat_i = 0;
  bit pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ($urandom_range(0, 99) < 60);
      2: begin
        m_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 6;
      end
      default: m_ready = 1'b0;
    endcase
    if (emp_mode != 0) hold_empty = ($urandom_range(0, 99) < 25);
  end

  // Monitor
  bit         done_pend = 0;
  bit         stall_prev = 0;
  logic [W-1:0] stall_dat = '0;
  int         hs_cnt = 0;
  int         rd_base = 0;

  always @(negedge clk) begin : mon
    int outst;
    bit hs;
    logic [W:0] e;
    if (reset) begin
      exp_q.delete();
      exp_len.delete();
      done_pend  = 0;
      stall_prev = 0;
      hs_cnt     = 0;
      rd_base    = rd_q;
    end else begin
      hs = m_valid && m_ready;
      chk("done", {31'd0, done}, {31'd0, done_pend});
      if (done_pend) begin
        if (exp_len.size() > 0)
          chk("words_sent", {24'd0, words_sent}, exp_len.pop_front());
        frames_seen++;
      end
      done_pend = 0;
      if (start && zlen) done_pend = 1;
      if (stall_prev) begin
        chk("hold_valid", {31'd0, m_valid}, 1);
        chk("hold_data", {16'd0, m_data}, {16'd0, stall_dat});
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", {15'd0, m_last, m_data}, {15'd0, e});
          if (e[W]) done_pend = 1;
        end
      end
      if (fifo_read) begin
        outst = rd_q - rd_base - hs_cnt;
        chk("read_empty", {31'd0, fifo_empty}, 0);
        chk("credit", {31'd0, (outst + 1 - int'(hs)) <= 2}, 1);
      end
      if (hs) hs_cnt++;
      stall_prev = m_valid && !m_ready;
      stall_dat  = m_data;
    end
  end

  // Stimulus helpers (all drive at posedge + 1)
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr % 4096] = 16'($urandom);
      wr++;
    end
  endtask

  task automatic issue(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), mem[(exp_rd + i) % 4096]});
    exp_rd += n;
    exp_len.push_back(n);
    frame_len = LW'(n);
    zlen  = (n == 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    zlen  = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (frames_seen == base && t < 3000) begin
      cyc(1);
      t++;
    end
    chk("frame_timeout", {31'd0, frames_seen != base}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int r0;
    int n;
    logic [2:0] ev;

    cyc(2);
    @(negedge clk);
    chk("reset_state",
        {3'd0, busy, done, fifo_read, m_valid, m_last, m_data, words_sent}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(2);

    // Latency / throughput frame of 4
    base = frames_seen;
    load(4);
    issue(4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ev = {(k >= 1 && k <= 4), (k >= 3 && k <= 6), (k == 7)};
      chk("t1_timing", {29'd0, fifo_read, m_valid, done}, {29'd0, ev});
      @(posedge clk);
      #1;
    end
    wait_done(base);

    // Toggling ready pattern
    rdy_mode = 2;
    pat_i = 0;
    cyc(1);
    base = frames_seen;
    load(3);
    issue(3);
    wait_done(base);
    rdy_mode = 0;
    cyc(2);

    // FIFO empty for 5 cycles after the first word
    base = frames_seen;
    r0 = rd_q;
    load(3);
    issue(3);
    for (int t = 0; t < 20 && rd_q == r0; t++) cyc(1);
    hold_empty = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_no_read", {31'd0, fifo_read}, 0);
      @(posedge clk);
      #1;
    end
    hold_empty = 1'b0;
    wait_done(base);
    cyc(2);

    // Zero-length frame with data waiting in the FIFO
    load(2);
    base = frames_seen;
    issue(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_idle", {29'd0, fifo_read, m_valid, busy}, 0);
      @(posedge clk);
      #1;
    end
    chk("t4_done_seen", {31'd0, frames_seen != base}, 1);
    cyc(1);

    // start while busy is ignored
    load(3 + 9);
    base = frames_seen;
    issue(5);
    frame_len = LW'(9);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(base);
    cyc(2);

    // Randomised frames with backpressure and empty gaps
    rdy_mode = 1;
    emp_mode = 1;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 12);
      load(n + $urandom_range(0, 2));
      base = frames_seen;
      issue(n);
      wait_done(base);
      cyc($urandom_range(0, 2));
    end
    emp_mode = 0;
    rdy_mode = 0;
    @(posedge clk);
    #2;
    hold_empty = 1'b0;
    cyc(3);

    // Reset mid-frame with two words buffered
    rdy_mode = 3;
    cyc(2);
    load(6);
    issue(6);
    cyc(6);
    #2;
    chk("pre_rst_valid", {31'd0, m_valid}, 1);
    reset = 1'b1;
    #1;
    chk("rst_async", {29'd0, m_valid, fifo_read, busy}, 0);
    chk("rst_regs", {8'd0, m_data, words_sent}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd = rd_q;
    rdy_mode = 0;
    cyc(2);
    base = frames_seen;
    issue(wr - exp_rd);
    wait_done(base);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Consumer-side controller for the buffering FIFO: pops a frame of exactly frame_len words from the FIFO's read port and presents them downstream on a valid/ready stream.
- Marks the final word of the frame with m_last.
- Contains a 2-entry skid buffer so downstream backpressure never drops a word. FIFO read data arrives one cycle after the read strobe.
- Sits between the detector sample FIFO and the inference input stage.

Parameters:
WORD_SIZE, 16, width of FIFO words and stream data
LEN_W, 8, width of frame length and word counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to read one frame; sampled only in IDLE
frame_len  input  LEN_W  number of words in the frame; latched with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last word is accepted downstream
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  FIFO pop strobe
fifo_data  input  WORD_SIZE  FIFO read data; valid the cycle after fifo_read=1
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word when m_valid & m_ready
m_data  output  WORD_SIZE  stream data, the head of the skid buffer
m_last  output  1  head word is word index frame_len-1
words_sent  output  LEN_W  words accepted downstream in the current or most recent frame

Behaviour:
- Reset (asynchronous, any time including mid-frame) forces the following:
  - State to IDLE.
  - busy=0, done=0, fifo_read=0, m_valid=0, m_last=0, m_data=0, words_sent=0.
  - Skid buffer and in-flight flag are cleared; the length latch and issue counter are cleared.
- States:
  - IDLE, then on start with frame_len>0 go to STREAM. Latch frame_len, clear the issue counter and words_sent.
  - IDLE, then on start with frame_len=0: no FIFO reads, done pulses in the next cycle, stay in IDLE.
  - STREAM: issue reads. Go to FLUSH when issued == len_latched.
  - FLUSH: no reads. Go to IDLE on the handshake of the m_last word. done=1 in the following cycle only.
  - start is ignored in STREAM and FLUSH.
- fifo_read = (state==STREAM) & ~fifo_empty & (issued < len_latched) & (occ + inflight - pop < 2).
  - occ = skid entries (0..2).
  - inflight = a read was issued in the previous cycle.
  - pop = m_valid & m_ready.
- fifo_read is never high while fifo_empty=1.
- A word arriving on fifo_data (inflight=1) is written to the skid buffer tail in that cycle. The buffer is strictly in order.
- m_valid = (occ>0). m_data and m_last reflect the head entry and hold stable while m_valid & ~m_ready.
- Each entry carries a last tag, set when its issue index == len_latched-1.
- words_sent increments on each handshake and saturates never: it cannot exceed len_latched.
- Latency: start in cycle 0, then fifo_read in cycle 1, fifo_data in cycle 2, m_valid in cycle 3.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and m_ready=1.
- Boundary conditions:
  - FIFO goes empty mid-frame: reads pause and resume when fifo_empty deasserts.
  - m_ready low for long: at most 2 words are buffered plus 0 in flight; reads stall.
  - Simultaneous push and pop with occ=2 cannot occur, by the credit rule.
- busy = (state != IDLE).
- The issue and handshake counters never wrap within a frame; len_latched ≤ 2^LEN_W - 1.

Test Plan:
- Reset, FIFO holds 4 words A0..A3, frame_len=4, m_ready=1, start pulse in cycle 0. Required response:
  - fifo_read high in cycles 1-4.
  - m_valid in cycles 3-6 with data A0..A3.
  - m_last only with A3.
  - done in cycle 7, words_sent=4.
- frame_len=3 with m_ready toggling 1,0,0,1,0,1. Required response:
  - No word is lost or duplicated; m_data is stable while stalled.
  - fifo_read is never issued when occ+inflight would reach 3.
- FIFO empty for 5 cycles after the first word of a 3-word frame. Required response:
  - fifo_read stays 0 during the empty period.
  - Streaming resumes and m_last marks the third word.
- start with frame_len=0. Required response: done pulses the next cycle, fifo_read and m_valid are never asserted, busy stays 0.
- start pulsed again while busy. Required response: it is ignored, frame_len is not relatched, and exactly the original count is read.
- reset asserted mid-frame with 2 words buffered. Required response:
  - m_valid, fifo_read and busy go 0 immediately (asynchronously).
  - A new start after reset reads a fresh frame correctly.
